rr_xmtr: RTL
============

RR_XMTR -- requirements
Module: rr_xmtr

Interface
REQ-001 Parameter PULSE_LEN, default 2: number of CLOCK cycles each data pulse is held on RRIN0/RRIN1 (legal range 1..7).
REQ-002 Parameter WORD_BITS, default 15: bits per radar word.
REQ-003 CLOCK  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 RRSYNC  input  1  bit-sync strobe from the AGC, synchronous to CLOCK; one rising edge requests one bit.
REQ-006 RRRANG  input  1  level select: transmit range word.
REQ-007 RRRARA  input  1  level select: transmit range-rate word.
REQ-008 RANGE_DATA  input  WORD_BITS  range sample from the radar model.
REQ-009 RATE_DATA  input  WORD_BITS  range-rate sample from the radar model.
REQ-010 RRIN0  output  1  "data bit = 0" pulse to the AGC.
REQ-011 RRIN1  output  1  "data bit = 1" pulse to the AGC.
REQ-012 BUSY  output  1  high while a word is latched and not yet fully sent.
REQ-013 DONE  output  1  one-cycle pulse after the last bit's pulse ends.
REQ-014 ERR  output  1  sticky select-conflict flag.

Function
REQ-015 States: IDLE, ARMED, PULSE, HOLD; all outputs registered.
REQ-016 Select activation: a 0->1 transition of (RRRANG XOR RRRARA) in IDLE, sampled on the prior and current cycle, SHALL latch RANGE_DATA if RRRANG else RATE_DATA into the shift register, clear the bit counter, and enter ARMED; BUSY=1 from the next cycle.
REQ-017 Conflict: RRRANG and RRRARA both high in any state SHALL set ERR, abort any transfer to IDLE without DONE, and force RRIN0=RRIN1=0 on the next edge.
REQ-018 ERR clears only on rst or on a cycle where both selects are low.
REQ-019 Sync edge: one where RRSYNC=1 and the registered previous RRSYNC=0.
REQ-020 A sync edge in ARMED SHALL, on that cycle's closing edge, assert RRIN1 if the current MSB is 1, else RRIN0, and enter PULSE. Exactly one of RRIN0/RRIN1 is high.
REQ-021 Bits SHALL be sent MSB first; the register shifts left by one per bit sent.
REQ-022 PULSE SHALL hold the output exactly PULSE_LEN cycles, then drop it and return to ARMED, or go to HOLD after bit WORD_BITS.
REQ-023 Sync edges during PULSE, HOLD or IDLE SHALL be ignored; they do not queue.
REQ-024 Entering HOLD: DONE=1 for one cycle and BUSY=0 on the same edge.
REQ-025 HOLD SHALL persist until the active select drops, then go to IDLE; a new word requires a fresh select rising edge.
REQ-026 Active select dropping in ARMED or PULSE SHALL abort to IDLE: outputs low next edge, BUSY=0, no DONE.
REQ-027 RANGE_DATA/RATE_DATA changes after latch SHALL NOT affect the word in flight.
REQ-028 The bit counter SHALL saturate at WORD_BITS and never wrap.

Reset
REQ-029 While rst=1: state IDLE, shift register 0, counter 0, previous-sync and previous-select registers 0, RRIN0=RRIN1=BUSY=DONE=ERR=0, asynchronously.
REQ-030 rst asserted mid-word SHALL discard the word; after release, RRRANG already high SHALL NOT start a transfer until it goes low and high again.

Verification
REQ-031 Range word: RANGE_DATA=15'b101010101010101, RRRANG rise, 15 sync edges spaced 6 cycles -> RRIN1,RRIN0,... alternating, each exactly 2 cycles; DONE once, 2 cycles after the 15th sync edge; BUSY low thereafter.
REQ-032 Rate word: RATE_DATA=15'h0001, RRRARA rise, 15 syncs -> fourteen RRIN0 pulses then one RRIN1; RANGE_DATA toggling throughout has no effect.
REQ-033 Sync during pulse: second sync edge 1 cycle after the first, PULSE_LEN=3 -> only one pulse of 3 cycles; bit counter advances by 1.
REQ-034 Abort: RRRANG drops after bit 7 -> outputs 0 and BUSY 0 next cycle, no DONE; later syncs produce no pulses.
REQ-035 Conflict: RRRARA raised while RRRANG high mid-word -> ERR=1, transfer aborted; ERR stays 1 until both low, then 0.
REQ-036 Reset mid-pulse: rst during an RRIN1 pulse -> RRIN1 drops immediately without waiting for a clock edge; with RRRANG held high through release -> no transfer until RRRANG is cycled.

Source files
------------

// File: rtl/rr_xmtr.sv
`default_nettype none
// ============================================================================
// Module      : rr_xmtr
// Description : Rendezvous-radar word transmitter. Latches a range or
//               range-rate word on a select rising edge and sends it MSB
//               first, one RRIN1/RRIN0 pulse per AGC bit-sync edge.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_xmtr #(
    parameter int PULSE_LEN = 2,
    parameter int WORD_BITS = 15
) (
    input  logic                 CLOCK,
    input  logic                 rst,
    input  logic                 RRSYNC,
    input  logic                 RRRANG,
    input  logic                 RRRARA,
    input  logic [WORD_BITS-1:0] RANGE_DATA,
    input  logic [WORD_BITS-1:0] RATE_DATA,
    output logic                 RRIN0,
    output logic                 RRIN1,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR
);

    localparam int                c_CW        = $clog2(WORD_BITS + 1);
    localparam logic [c_CW-1:0]   c_WORD_BITS = c_CW'(WORD_BITS);
    localparam logic [2:0]        c_PULSE_LEN = 3'(PULSE_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [WORD_BITS-1:0]  r_shreg, w_shreg_nxt;
    logic [c_CW-1:0]       r_cnt, w_cnt_nxt;
    logic [2:0]            r_plen, w_plen_nxt;
    logic                  r_use_range, w_use_range_nxt;
    logic                  r_rrin0, w_rrin0_nxt;
    logic                  r_rrin1, w_rrin1_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_sync_prev;
    logic                  r_sel_prev;
    logic                  r_sel_ok;

    logic w_sel;
    logic w_sel_rise;
    logic w_sel_drop;
    logic w_conflict;
    logic w_sync_edge;
    logic w_abort;

    // A select rising edge only counts once the select has been seen low
    // since reset, so a select held high through reset release is ignored.
    assign w_sel       = RRRANG ^ RRRARA;
    assign w_sel_rise  = w_sel & ~r_sel_prev & r_sel_ok;
    assign w_conflict  = RRRANG & RRRARA;
    assign w_sel_drop  = r_use_range ? ~RRRANG : ~RRRARA;
    assign w_sync_edge = RRSYNC & ~r_sync_prev;
    assign w_abort     = w_conflict | w_sel_drop;

    // State and output registers; all outputs come straight from flops.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_plen      <= '0;
            r_use_range <= 1'b0;
            r_rrin0     <= 1'b0;
            r_rrin1     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_sync_prev <= 1'b0;
            r_sel_prev  <= 1'b0;
            r_sel_ok    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_plen      <= w_plen_nxt;
            r_use_range <= w_use_range_nxt;
            r_rrin0     <= w_rrin0_nxt;
            r_rrin1     <= w_rrin1_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_sync_prev <= RRSYNC;
            r_sel_prev  <= w_sel;
            r_sel_ok    <= r_sel_ok | ~w_sel;
        end
    end

    // Next-state and next-output logic; aborts force pulses low and clear BUSY.
    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_cnt_nxt       = r_cnt;
        w_plen_nxt      = r_plen;
        w_use_range_nxt = r_use_range;
        w_rrin0_nxt     = r_rrin0;
        w_rrin1_nxt     = r_rrin1;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        if (w_conflict) begin
            w_err_nxt = 1'b1;
        end else if (!RRRANG && !RRRARA) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end

        case (r_state)
            S_IDLE: begin
                w_rrin0_nxt = 1'b0;
                w_rrin1_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                if (w_sel_rise) begin
                    w_shreg_nxt     = RRRANG ? RANGE_DATA : RATE_DATA;
                    w_cnt_nxt       = '0;
                    w_use_range_nxt = RRRANG;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_rrin0_nxt = 1'b0;
                    w_rrin1_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (w_sync_edge) begin
                    w_rrin1_nxt = r_shreg[WORD_BITS-1];
                    w_rrin0_nxt = ~r_shreg[WORD_BITS-1];
                    w_shreg_nxt = {r_shreg[WORD_BITS-2:0], 1'b0};
                    w_cnt_nxt   = (r_cnt == c_WORD_BITS) ? r_cnt : r_cnt + c_CW'(1);
                    w_plen_nxt  = 3'd1;
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                    w_rrin0_nxt = 1'b0;
                    w_rrin1_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (r_plen >= c_PULSE_LEN) begin
                    w_rrin0_nxt = 1'b0;
                    w_rrin1_nxt = 1'b0;
                    if (r_cnt == c_WORD_BITS) begin
                        w_state_nxt = S_HOLD;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_ARMED;
                    end
                end else begin
                    w_plen_nxt = r_plen + 3'd1;
                end
            end
            S_HOLD: begin
                w_busy_nxt = 1'b0;
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign RRIN0 = r_rrin0;
    assign RRIN1 = r_rrin1;
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign ERR   = r_err;

endmodule
`default_nettype wire
